// File: rtl/vga_timing_gen.sv
// Purpose: parametrised VGA raster timing (sync, active area, coordinates, lookahead prefetch, strobes, frame count).
// Latency: counters, syncs and lookahead channels are registered; valid/coords/strobes decode combinationally off the counters.
// Backpressure: none; en is a pixel tick and every register holds while en=0.
module vga_timing_gen #(
   parameter int H_DISP    = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_DISP    = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int HS_POL    = 0,
   parameter int VS_POL    = 0,
   parameter int LOOKAHEAD = 6,
   parameter int CW        = 10
) (
   input  logic                    pclk,
   input  logic                    reset,
   input  logic                    en,
   output logic                    hsync,
   output logic                    vsync,
   output logic                    valid,
   output logic [CW-1:0]           h_cnt,
   output logic [CW-1:0]           v_cnt,
   output logic [LOOKAHEAD*CW-1:0] la_h,
   output logic [LOOKAHEAD*CW-1:0] la_v,
   output logic [LOOKAHEAD-1:0]    la_valid,
   output logic                    line_start,
   output logic                    frame_start,
   output logic                    vblank,
   output logic [7:0]              frame_cnt
);

   localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;

   // Wide (CW+1) constants so comparisons never truncate even when a bound equals 2**CW.
   localparam logic [CW:0]   H_TOTAL_W = (CW+1)'(H_TOTAL);
   localparam logic [CW:0]   H_DISP_W  = (CW+1)'(H_DISP);
   localparam logic [CW:0]   V_DISP_W  = (CW+1)'(V_DISP);
   localparam logic [CW:0]   HS_BEG_W  = (CW+1)'(H_DISP + H_FP);
   localparam logic [CW:0]   HS_END_W  = (CW+1)'(H_DISP + H_FP + H_SYNC);
   localparam logic [CW:0]   VS_BEG_W  = (CW+1)'(V_DISP + V_FP);
   localparam logic [CW:0]   VS_END_W  = (CW+1)'(V_DISP + V_FP + V_SYNC);
   localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] ONE       = CW'(1);
   localparam logic          HS_ACT    = (HS_POL != 0);
   localparam logic          VS_ACT    = (VS_POL != 0);

   logic [CW-1:0] pix_q, pix_d;
   logic [CW-1:0] line_q, line_d;
   logic [7:0]    frame_q, frame_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;

   // Next raster position; reset forces the origin so the lookahead reloads its (0,0) view.
   always_comb begin
      pix_d   = pix_q;
      line_d  = line_q;
      frame_d = frame_q;
      if (reset) begin
         pix_d   = '0;
         line_d  = '0;
         frame_d = '0;
      end else if (en) begin
         if (pix_q == H_LAST) begin
            pix_d = '0;
            if (line_q == V_LAST) begin
               line_d  = '0;
               frame_d = frame_q + 8'd1;
            end else begin
               line_d = line_q + ONE;
            end
         end else begin
            pix_d = pix_q + ONE;
         end
      end
   end

   // Syncs decode the next position so the registered level lines up with the counters.
   always_comb begin
      hsync_d = (({1'b0, pix_d} >= HS_BEG_W) && ({1'b0, pix_d} < HS_END_W)) ? HS_ACT : ~HS_ACT;
      vsync_d = (({1'b0, line_d} >= VS_BEG_W) && ({1'b0, line_d} < VS_END_W)) ? VS_ACT : ~VS_ACT;
   end

   // Raster state: reset wins over en, en=0 freezes everything.
   always_ff @(posedge pclk) begin
      if (reset) begin
         pix_q   <= '0;
         line_q  <= '0;
         frame_q <= '0;
         hsync_q <= ~HS_ACT;
         vsync_q <= ~VS_ACT;
      end else if (en) begin
         pix_q   <= pix_d;
         line_q  <= line_d;
         frame_q <= frame_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign valid       = ({1'b0, pix_q} < H_DISP_W) && ({1'b0, line_q} < V_DISP_W);
   assign h_cnt       = valid ? pix_q : '0;
   assign v_cnt       = valid ? line_q : '0;
   assign line_start  = (pix_q == '0);
   assign frame_start = (pix_q == '0) && (line_q == '0);
   assign vblank      = ({1'b0, line_q} >= V_DISP_W);
   assign frame_cnt   = frame_q;

   for (genvar g = 0; g < LOOKAHEAD; g++) begin : g_la
      localparam logic [CW:0] K = (CW+1)'(g + 1);

      logic [CW:0]   x_sum;
      logic [CW-1:0] x_raw, y_raw;
      logic [CW-1:0] x_d, y_d, x_q, y_q;
      logic          act_d, act_q;

      // Position k ticks ahead of the next beam position; k is below the blanking width,
      // so at most one horizontal wrap (and at most one line step) can occur.
      always_comb begin
         x_sum = {1'b0, pix_d} + K;
         x_raw = x_sum[CW-1:0];
         y_raw = line_d;
         if (x_sum >= H_TOTAL_W) begin
            x_raw = CW'(x_sum - H_TOTAL_W);
            y_raw = (line_d == V_LAST) ? '0 : line_d + ONE;
         end
         act_d = ({1'b0, x_raw} < H_DISP_W) && ({1'b0, y_raw} < V_DISP_W);
         x_d   = act_d ? x_raw : '0;
         y_d   = act_d ? y_raw : '0;
      end

      // Prefetch channel register tracks the counters; reset reloads it from the origin.
      always_ff @(posedge pclk) begin
         if (reset || en) begin
            x_q   <= x_d;
            y_q   <= y_d;
            act_q <= act_d;
         end
      end

      assign la_h[g*CW +: CW] = x_q;
      assign la_v[g*CW +: CW] = y_q;
      assign la_valid[g]      = act_q;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator for the display path. Produces hsync/vsync, the active-area flag and current pixel coordinates.
- Adds LOOKAHEAD prefetch coordinate channels so renderers with multi-cycle ROM/pipeline latency can address pixels ahead of the beam.
- Successor to the fixed 640x480 controller: generic timing, sync polarity, pixel-enable gating, and frame/line strobes plus a frame counter.
- Single clock domain only; no negedge logic.

Parameters:
- H_DISP, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_DISP, 480, active lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- LOOKAHEAD, 6, number of prefetch channels. Legal range 1..15 and < H_FP+H_SYNC+H_BP.
- CW, 10, coordinate width. Must hold H_TOTAL-1 and V_TOTAL-1.

Ports:
- pclk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- en  in  1  pixel tick; all state advances only on cycles with en=1
- hsync  out  1  horizontal sync, registered
- vsync  out  1  vertical sync, registered
- valid  out  1  beam is inside the active area
- h_cnt  out  CW  active x coordinate, 0 outside the active area
- v_cnt  out  CW  active y coordinate, 0 outside the active area
- la_h  out  LOOKAHEAD*CW  channel k (1-based) in slice [(k-1)*CW +: CW]: active x of the beam position k ticks ahead
- la_v  out  LOOKAHEAD*CW  channel k: active y k ticks ahead
- la_valid  out  LOOKAHEAD  bit k-1: position k ticks ahead is active
- line_start  out  1  high while pixel_cnt==0
- frame_start  out  1  high while pixel_cnt==0 and line_cnt==0
- vblank  out  1  line_cnt >= V_DISP
- frame_cnt  out  8  count of completed frames, wraps 255->0

Behaviour:
- Derived totals: H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Internal counters pixel_cnt (0..H_TOTAL-1) and line_cnt (0..V_TOTAL-1).
- On en: pixel_cnt increments. At H_TOTAL-1 it wraps to 0 and line_cnt increments. line_cnt wraps to 0 after V_TOTAL-1.
- On en with pixel_cnt==H_TOTAL-1 and line_cnt==V_TOTAL-1: frame_cnt increments.
- en=0: every register holds, including outputs, and the strobes keep their level.
- hsync/vsync are registered so they stay aligned with the counters: after any tick, hsync is active iff the new pixel_cnt is in [H_DISP+H_FP, H_DISP+H_FP+H_SYNC-1]. vsync uses the same rule with line_cnt and the V parameters. Active level is set by HS_POL/VS_POL; otherwise the inactive level.
- Active area: valid = pixel_cnt<H_DISP && line_cnt<V_DISP. h_cnt/v_cnt are the raw counters when valid, else 0. valid, h_cnt, v_cnt, line_start, frame_start and vblank are decoded from registered counters (zero latency relative to them).
- Lookahead channel k:
  - Let P = (line_cnt*H_TOTAL + pixel_cnt + k) mod (H_TOTAL*V_TOTAL), with x = P mod H_TOTAL and y = P div H_TOTAL.
  - la_valid[k] = x<H_DISP && y<V_DISP.
  - la_h = x and la_v = y when la_valid[k]=1; both are 0 otherwise.
  - The channels are registered (computed from next-state counters) and must equal this formula in every cycle, including line wrap and frame wrap.
  - Implementation must not use a multiplier or divider: use per-channel incrementing counters or a compare-and-wrap on pixel_cnt+k.
- Reset (pclk edge with reset=1, overrides en):
  - pixel_cnt=0, line_cnt=0, frame_cnt=0.
  - hsync=~HS_POL, vsync=~VS_POL.
  - Lookahead registers loaded with the formula values for (0,0), i.e. channel k = (x=k, y=0, valid=1).
  - Consequently, right after reset: valid=1, line_start=1, frame_start=1, vblank=0.
  - Reset mid-frame behaves identically; there is no residual state.

Test Plan:
- Reset with defaults -> h_cnt=0, v_cnt=0, valid=1, hsync=vsync=1, frame_cnt=0, la_h ch6=6, frame_start=1.
- en=1 continuous, line 0 -> hsync low exactly for pixel_cnt 656..751 (96 ticks). valid falls at pixel 640. line_start pulses once per 800 ticks.
- Line 10 pixel 797 -> ch4 gives la_h=1, la_v=11, la_valid=1. ch1 at pixel 639 -> la_valid=0, la_h=0, la_v=0.
- Frame wrap from (799,524) -> ch1 reports (0,0) valid. Next tick counters read (0,0), frame_start=1, frame_cnt increments. vsync low only for lines 490..491; vblank high for lines 480..524.
- en toggled 1-0-0-0-1 at random points -> all outputs frozen during en=0. Sequence equals the en=1 reference with stalls removed.
- HS_POL=1, small timing (H 8/2/2/2, V 4/1/1/1), LOOKAHEAD=3, reset asserted mid-line -> hsync active-high at pixels 10..11; reset returns counters to 0 on the next edge; lookahead matches the formula every cycle.
